// File: rtl/regfile_seq.sv
`default_nettype none
// ============================================================================
// Module  : regfile_seq
// Brief   : Sequencer/arbiter for the RNBIP-2 register file. Grants either an
//           ALU write-back or a decoded micro-command, one at a time, and drives
//           the file's enab/seg/mux_sel/reg_sel lines for each access.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_seq #(
  parameter int READ_LAT = 1,  // cycles enab=11 is held before read data is valid (1..7)
  parameter int WB_BURST = 4   // max back-to-back write-backs while a command waits (1..15)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_dst,
  input  logic [2:0] cmd_src,
  input  logic       wb_req,
  input  logic [2:0] wb_dst,
  output logic       wb_ack,
  output logic [1:0] enab,
  output logic [2:0] seg,
  output logic [1:0] mux_sel,
  output logic [2:0] reg_sel,
  output logic       rd_valid,
  output logic       cmd_err
);

  localparam logic [2:0] c_op_nop      = 3'b000;
  localparam logic [2:0] c_op_load_or  = 3'b001;
  localparam logic [2:0] c_op_move     = 3'b010;
  localparam logic [2:0] c_op_load_alu = 3'b011;
  localparam logic [2:0] c_op_read     = 3'b100;

  localparam logic [1:0] c_enab_idle  = 2'b00;
  localparam logic [1:0] c_enab_write = 2'b01;
  localparam logic [1:0] c_enab_read  = 2'b11;

  localparam logic [1:0] c_mux_none = 2'b00;
  localparam logic [1:0] c_mux_reg  = 2'b01;
  localparam logic [1:0] c_mux_or2  = 2'b10;
  localparam logic [1:0] c_mux_alu  = 2'b11;

  localparam logic [3:0] c_burst_max = 4'(WB_BURST);
  localparam logic [2:0] c_read_lat  = 3'(READ_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RDONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_burst;  // write-backs granted while the current command waited
  logic [2:0] r_lat;    // cycles spent so far in ST_READ

  logic w_idle;
  logic w_burst_full;
  logic w_wb_grant;
  logic w_cmd_grant;

  // Handshakes are decided in the grant cycle itself, so they are derived
  // combinationally from the registered state and the current requests.
  assign w_idle       = (r_state == ST_IDLE) && !reset;
  assign w_burst_full = (r_burst >= c_burst_max);
  assign w_wb_grant   = w_idle && wb_req && !(cmd_valid && w_burst_full);
  assign w_cmd_grant  = w_idle && cmd_valid && !w_wb_grant;
  assign cmd_ready    = w_idle && !w_wb_grant;
  assign wb_ack       = w_wb_grant;

  // Burst counter: counts write-backs that jumped ahead of a waiting command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_burst <= 4'd0;
    end else if (!cmd_valid || w_cmd_grant) begin
      r_burst <= 4'd0;
    end else if (w_wb_grant) begin
      r_burst <= r_burst + 4'd1;
    end
  end

  // Access sequencer: state plus all registered register-file control lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_lat    <= 3'd0;
      enab     <= c_enab_idle;
      seg      <= 3'd0;
      mux_sel  <= c_mux_none;
      reg_sel  <= 3'd0;
      rd_valid <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      cmd_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          enab    <= c_enab_idle;
          seg     <= 3'd0;
          mux_sel <= c_mux_none;
          reg_sel <= 3'd0;
          if (w_wb_grant) begin
            r_state <= ST_WRITE;
            enab    <= c_enab_write;
            seg     <= wb_dst;
            mux_sel <= c_mux_alu;
          end else if (w_cmd_grant) begin
            case (cmd_op)
              c_op_nop: begin
              end
              c_op_load_or: begin
                r_state <= ST_WRITE;
                enab    <= c_enab_write;
                seg     <= cmd_dst;
                mux_sel <= c_mux_or2;
              end
              c_op_move: begin
                // src == dst is deliberately not short-circuited.
                r_state <= ST_WRITE;
                enab    <= c_enab_write;
                seg     <= cmd_dst;
                mux_sel <= c_mux_reg;
                reg_sel <= cmd_src;
              end
              c_op_load_alu: begin
                r_state <= ST_WRITE;
                enab    <= c_enab_write;
                seg     <= cmd_dst;
                mux_sel <= c_mux_alu;
              end
              c_op_read: begin
                r_state <= ST_READ;
                r_lat   <= 3'd1;
                enab    <= c_enab_read;
                seg     <= cmd_dst;
              end
              default: begin
                cmd_err <= 1'b1;
              end
            endcase
          end
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
          enab    <= c_enab_idle;
          seg     <= 3'd0;
          mux_sel <= c_mux_none;
          reg_sel <= 3'd0;
        end
        ST_READ: begin
          // enab/seg stay as loaded; RDONE keeps them while data is presented.
          if (r_lat >= c_read_lat) begin
            r_state  <= ST_RDONE;
            rd_valid <= 1'b1;
          end else begin
            r_lat <= r_lat + 3'd1;
          end
        end
        ST_RDONE: begin
          r_state <= ST_IDLE;
          enab    <= c_enab_idle;
          seg     <= 3'd0;
          mux_sel <= c_mux_none;
          reg_sel <= 3'd0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_seq
// Brief   : Self-checking bench for regfile_seq with a behavioural register
//           file, directed vector table, corner sequences and random traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_seq;

  localparam int READ_LAT = 1;
  localparam int WB_BURST = 4;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_dst;
  logic [2:0] cmd_src;
  logic       wb_req;
  logic [2:0] wb_dst;
  logic       wb_ack;
  logic [1:0] enab;
  logic [2:0] seg;
  logic [1:0] mux_sel;
  logic [2:0] reg_sel;
  logic       rd_valid;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;

  logic [7:0] or2;
  logic [7:0] alu_in;
  logic [7:0] rf [8];
  logic [7:0] dataout_a;

  regfile_seq #(.READ_LAT(READ_LAT), .WB_BURST(WB_BURST)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src),
    .wb_req(wb_req), .wb_dst(wb_dst), .wb_ack(wb_ack),
    .enab(enab), .seg(seg), .mux_sel(mux_sel), .reg_sel(reg_sel),
    .rd_valid(rd_valid), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register1: writes on the edge while enab=01.
  initial for (int i = 0; i < 8; i++) rf[i] = 8'h00;
  always @(posedge clk) begin
    if (enab == 2'b01) begin
      case (mux_sel)
        2'b01:   rf[seg] <= rf[reg_sel];
        2'b10:   rf[seg] <= or2;
        2'b11:   rf[seg] <= alu_in;
        default: ;
      endcase
    end
  end
  assign dataout_a = rf[seg];

  always @(negedge clk) if (rd_valid === 1'b1) rd_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present a command and hold it until accepted (bounded); returns just after the accept edge.
  task automatic send_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src);
    int n;
    n = 0;
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Directed vectors
  typedef struct {
    logic [2:0] op, dst, src;
    logic [7:0] or2v, aluv;
    logic [1:0] enab;
    logic [2:0] seg;
    logic [1:0] mux;
    logic [2:0] rs;
    logic       err, ready, is_rd;
    logic [7:0] data;
  } vec_t;

  function automatic vec_t mkv(logic [2:0] op, logic [2:0] dst, logic [2:0] src,
                               logic [7:0] o, logic [7:0] a, logic [1:0] e, logic [2:0] s,
                               logic [1:0] m, logic [2:0] r, logic er, logic rdy,
                               logic isr, logic [7:0] d);
    vec_t v;
    v.op = op; v.dst = dst; v.src = src; v.or2v = o; v.aluv = a;
    v.enab = e; v.seg = s; v.mux = m; v.rs = r; v.err = er; v.ready = rdy;
    v.is_rd = isr; v.data = d;
    return v;
  endfunction

  // Random-phase reference: a queue of upcoming output beats per granted access.
  typedef struct packed {
    logic [1:0] enab;
    logic [2:0] seg;
    logic [1:0] mux;
    logic [2:0] rs;
    logic       rd;
    logic       err;
  } beat_t;

  function automatic beat_t mkb(logic [1:0] e, logic [2:0] s, logic [1:0] m,
                                logic [2:0] r, logic rd, logic er);
    beat_t b;
    b.enab = e; b.seg = s; b.mux = m; b.rs = r; b.rd = rd; b.err = er;
    return b;
  endfunction

  vec_t tbl [13];

  initial begin
    int acks_before, rd_snap;
    logic got_cmd, resumed, both, ack, acc;
    beat_t cur, nxt, expb;
    beat_t q [$];
    int burst;
    logic e_ack, e_acc, e_ready, idle;

    tbl[0]  = mkv(3'b001, 3'd2, 3'd0, 8'h05, 8'h00, 2'b01, 3'd2, 2'b10, 3'd0, 0, 0, 0, 8'h00);
    tbl[1]  = mkv(3'b100, 3'd2, 3'd0, 8'h00, 8'h00, 2'b11, 3'd2, 2'b00, 3'd0, 0, 0, 1, 8'h05);
    tbl[2]  = mkv(3'b010, 3'd7, 3'd2, 8'h00, 8'h00, 2'b01, 3'd7, 2'b01, 3'd2, 0, 0, 0, 8'h00);
    tbl[3]  = mkv(3'b100, 3'd7, 3'd0, 8'h00, 8'h00, 2'b11, 3'd7, 2'b00, 3'd0, 0, 0, 1, 8'h05);
    tbl[4]  = mkv(3'b011, 3'd4, 3'd0, 8'h00, 8'h3c, 2'b01, 3'd4, 2'b11, 3'd0, 0, 0, 0, 8'h00);
    tbl[5]  = mkv(3'b100, 3'd4, 3'd0, 8'h00, 8'h00, 2'b11, 3'd4, 2'b00, 3'd0, 0, 0, 1, 8'h3c);
    tbl[6]  = mkv(3'b000, 3'd3, 3'd1, 8'h00, 8'h00, 2'b00, 3'd0, 2'b00, 3'd0, 0, 1, 0, 8'h00);
    tbl[7]  = mkv(3'b110, 3'd1, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 2'b00, 3'd0, 1, 1, 0, 8'h00);
    tbl[8]  = mkv(3'b111, 3'd5, 3'd6, 8'h00, 8'h00, 2'b00, 3'd0, 2'b00, 3'd0, 1, 1, 0, 8'h00);
    tbl[9]  = mkv(3'b010, 3'd4, 3'd4, 8'h00, 8'h00, 2'b01, 3'd4, 2'b01, 3'd4, 0, 0, 0, 8'h00);
    tbl[10] = mkv(3'b100, 3'd4, 3'd0, 8'h00, 8'h00, 2'b11, 3'd4, 2'b00, 3'd0, 0, 0, 1, 8'h3c);
    tbl[11] = mkv(3'b001, 3'd0, 3'd0, 8'ha5, 8'h00, 2'b01, 3'd0, 2'b10, 3'd0, 0, 0, 0, 8'h00);
    tbl[12] = mkv(3'b100, 3'd0, 3'd0, 8'h00, 8'h00, 2'b11, 3'd0, 2'b00, 3'd0, 0, 0, 1, 8'ha5);

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_dst = 3'd0; cmd_src = 3'd0;
    wb_req = 1'b0; wb_dst = 3'd0; or2 = 8'h00; alu_in = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_outputs", {18'd0, enab, seg, mux_sel, reg_sel, rd_valid, cmd_err, wb_ack}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a READ abandons it
    rd_snap = rd_cnt;
    send_cmd(3'b100, 3'd3, 3'd0);
    #2; reset = 1'b1; #1;
    chk("midrd_rst_enab", {30'd0, enab}, 32'd0);
    chk("midrd_rst_seg", {29'd0, seg}, 32'd0);
    chk("midrd_rst_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (2) @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("midrd_ready_after_release", {31'd0, cmd_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("midrd_no_rd_valid", rd_cnt, rd_snap);
    @(posedge clk); #1;

    // Vector table: one command at a time from idle
    for (int i = 0; i < 13; i++) begin
      or2 = tbl[i].or2v; alu_in = tbl[i].aluv;
      send_cmd(tbl[i].op, tbl[i].dst, tbl[i].src);
      @(negedge clk);
      chk($sformatf("v%0d_enab", i), {30'd0, enab}, {30'd0, tbl[i].enab});
      chk($sformatf("v%0d_seg", i), {29'd0, seg}, {29'd0, tbl[i].seg});
      chk($sformatf("v%0d_mux", i), {30'd0, mux_sel}, {30'd0, tbl[i].mux});
      chk($sformatf("v%0d_regsel", i), {29'd0, reg_sel}, {29'd0, tbl[i].rs});
      chk($sformatf("v%0d_err", i), {31'd0, cmd_err}, {31'd0, tbl[i].err});
      chk($sformatf("v%0d_ready", i), {31'd0, cmd_ready}, {31'd0, tbl[i].ready});
      chk($sformatf("v%0d_rdv_early", i), {31'd0, rd_valid}, 32'd0);
      if (tbl[i].is_rd) begin
        repeat (READ_LAT) @(negedge clk);
        chk($sformatf("v%0d_rd_valid", i), {31'd0, rd_valid}, 32'd1);
        chk($sformatf("v%0d_rd_enab", i), {30'd0, enab}, 32'd3);
        chk($sformatf("v%0d_rd_data", i), {24'd0, dataout_a}, {24'd0, tbl[i].data});
      end
      repeat (3) @(posedge clk); #1;
    end

    // Write-back and command together: write-back wins
    or2 = 8'h11; alu_in = 8'h77;
    wb_req = 1'b1; wb_dst = 3'd5;
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_dst = 3'd1; cmd_src = 3'd0;
    @(negedge clk);
    chk("arb_wb_ack", {31'd0, wb_ack}, 32'd1);
    chk("arb_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1; wb_req = 1'b0;
    @(negedge clk);
    chk("arb_wb_write", {23'd0, enab, seg, mux_sel}, {23'd0, 2'b01, 3'd5, 2'b11});
    chk("arb_ready_in_write", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arb_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("arb_cmd_write", {23'd0, enab, seg, mux_sel}, {23'd0, 2'b01, 3'd1, 2'b10});
    repeat (3) @(posedge clk); #1;

    // Held write-back vs waiting command: burst limit then resume
    acks_before = 0; got_cmd = 1'b0; resumed = 1'b0; both = 1'b0;
    wb_req = 1'b1; wb_dst = 3'd3;
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_dst = 3'd6;
    for (int i = 0; i < 60 && !resumed; i++) begin
      @(negedge clk);
      ack = wb_ack;
      acc = cmd_valid && cmd_ready;
      if (ack && acc) both = 1'b1;
      if (ack) begin
        if (got_cmd) resumed = 1'b1;
        else acks_before++;
      end
      if (acc) got_cmd = 1'b1;
      @(posedge clk); #1;
      if (acc) cmd_valid = 1'b0;
    end
    wb_req = 1'b0;
    chk("burst_acks_before_cmd", acks_before, WB_BURST);
    chk("burst_cmd_granted", {31'd0, got_cmd}, 32'd1);
    chk("burst_wb_resumed", {31'd0, resumed}, 32'd1);
    chk("burst_single_grant", {31'd0, both}, 32'd0);
    repeat (3) @(posedge clk); #1;

    // Randomized traffic against the beat-queue model
    cur = '0; burst = 0; q.delete();
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_dst   = 3'($urandom_range(0, 7));
      cmd_src   = 3'($urandom_range(0, 7));
      wb_req    = ($urandom_range(0, 1) == 1);
      wb_dst    = 3'($urandom_range(0, 7));
      @(negedge clk);
      nxt = '0;
      if (reset) begin
        expb = '0; e_ready = 1'b0; e_ack = 1'b0;
        q.delete(); burst = 0;
      end else begin
        expb    = cur;
        idle    = (cur.enab == 2'b00);
        e_ack   = idle && wb_req && !(cmd_valid && burst >= WB_BURST);
        e_acc   = idle && cmd_valid && !e_ack;
        e_ready = idle && !e_ack;
        if (e_ack) q.push_back(mkb(2'b01, wb_dst, 2'b11, 3'd0, 1'b0, 1'b0));
        else if (e_acc) begin
          case (cmd_op)
            3'b000: ;
            3'b001: q.push_back(mkb(2'b01, cmd_dst, 2'b10, 3'd0, 1'b0, 1'b0));
            3'b010: q.push_back(mkb(2'b01, cmd_dst, 2'b01, cmd_src, 1'b0, 1'b0));
            3'b011: q.push_back(mkb(2'b01, cmd_dst, 2'b11, 3'd0, 1'b0, 1'b0));
            3'b100: begin
              for (int k = 0; k < READ_LAT; k++)
                q.push_back(mkb(2'b11, cmd_dst, 2'b00, 3'd0, 1'b0, 1'b0));
              q.push_back(mkb(2'b11, cmd_dst, 2'b00, 3'd0, 1'b1, 1'b0));
            end
            default: nxt.err = 1'b1;
          endcase
        end
        if (q.size() > 0) nxt = q.pop_front();
        if (!cmd_valid || e_acc) burst = 0;
        else if (e_ack) burst++;
      end
      chk($sformatf("rand_c%0d", c),
          {18'd0, enab, seg, mux_sel, reg_sel, rd_valid, cmd_err, cmd_ready, wb_ack},
          {18'd0, expb.enab, expb.seg, expb.mux, expb.rs, expb.rd, expb.err, e_ready, e_ack});
      @(posedge clk); #1;
      cur = nxt;
    end
    reset = 1'b0; cmd_valid = 1'b0; wb_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
